ledmatrix_text_engine: RTL and testbench



---
 rtl/charmatrix_pkg.sv | 23 ++
 rtl/ledmatrix_text_engine_if.sv | 12 +
 rtl/text_buffer.sv | 40 ++++
 rtl/ledmatrix_text_engine.sv | 212 +++++++++++++++++++++
 tb/tb_ledmatrix_text_engine.sv | 333 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/charmatrix_pkg.sv
// Shared command bytes and render FSM states for the LED matrix text engine.
// Imported by the engine top and its sub-blocks.
package charmatrix_pkg;

   localparam logic [7:0] CMD_ESC     = 8'h1B;
   localparam logic [7:0] CMD_CLR     = 8'h0C;
   localparam logic [7:0] CMD_HOME    = 8'h0D;
   localparam logic [7:0] ESC_NOCOLOR = 8'hFF;
   localparam logic [7:0] PRINT_LO    = 8'h20;
   localparam logic [7:0] PRINT_HI    = 8'h7E;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SEND,
      ST_LATCH
   } state_e;

   function automatic logic is_print(input logic [7:0] b);
      return (b >= PRINT_LO) && (b <= PRINT_HI);
   endfunction

endpackage

// File: rtl/ledmatrix_text_engine_if.sv
// Valid/ready stream carrying a W-bit payload.
// master drives data/valid, slave drives ready.
interface ledmatrix_text_engine_if #(
   parameter int W = 8
) ();
   logic [W-1:0] data;
   logic         valid;
   logic         ready;

   modport master (output data, output valid, input ready);
   modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/text_buffer.sv
// Text + colour register file: one write port, one async read port, bulk clear.
// Ports: we/waddr/wchar/wcol write, clr wipes all, raddr -> rchar/rcol.
module text_buffer #(
   parameter int DEPTH = 16,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [7:0]    wchar_i,
   input  logic [3:0]    wcol_i,
   input  logic          clr_i,
   input  logic [AW-1:0] raddr_i,
   output logic [7:0]    rchar_o,
   output logic [3:0]    rcol_o
);
   logic [7:0] chr_q [DEPTH];
   logic [3:0] col_q [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            chr_q[i] <= '0;
            col_q[i] <= '0;
         end
      end else if (clr_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            chr_q[i] <= '0;
            col_q[i] <= '0;
         end
      end else if (we_i) begin
         chr_q[waddr_i] <= wchar_i;
         col_q[waddr_i] <= wcol_i;
      end
   end

   assign rchar_o = chr_q[raddr_i];
   assign rcol_o  = col_q[raddr_i];
endmodule

// File: rtl/ledmatrix_text_engine.sv
// UART-fed text engine: parses bytes into text/colour buffers and streams
// glyph pixels (rx in, pix out, external char/colour ROMs, latch/overrun).
module ledmatrix_text_engine
   import charmatrix_pkg::*;
#(
   parameter int MAX_CHARS   = 16,
   parameter int CHAR_W      = 5,
   parameter int CHAR_H      = 7,
   parameter int COLOR_W     = 24,
   parameter int REFRESH_DIV = 262144,
   parameter int SCROLL_DIV  = 8,
   localparam int PIX        = CHAR_W * CHAR_H,
   localparam int AW         = $clog2(MAX_CHARS)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [AW:0]            num_chars_i,
   input  logic                   scroll_en_i,
   input  logic [3:0]             rnd_color_i,
   ledmatrix_text_engine_if.slave  rx,
   output logic [7:0]             rom_addr_o,
   input  logic [PIX-1:0]         rom_data_i,
   output logic [3:0]             pal_addr_o,
   input  logic [COLOR_W-1:0]     pal_data_i,
   ledmatrix_text_engine_if.master pix,
   output logic                   pix_latch_o,
   output logic                   frame_overrun_o
);
   localparam int BW = $clog2(PIX);
   localparam int RW = $clog2(REFRESH_DIV);
   localparam int FW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
   localparam logic [AW:0] NC_MAX = (AW+1)'(MAX_CHARS);
   localparam logic [AW:0] NC_ONE = (AW+1)'(1);

   logic          rdy_q, esc_q, esc_d, stk_en_q, stk_en_d;
   logic [3:0]    stk_q, stk_d, wcol;
   logic [AW-1:0] wp_q, wp_d;
   logic          we, clr, acc, tick;
   logic [RW-1:0] cnt_q;
   logic [AW:0]   nc;

   state_e        st_q, st_d;
   logic [AW:0]   ncf_q, ncf_d;
   logic [AW-1:0] ci_q, ci_d, off_q, off_d, slot;
   logic [BW-1:0] bit_q, bit_d;
   logic [7:0]    rom_q, rom_d, rd_chr;
   logic [3:0]    pal_q, pal_d, rd_col;
   logic [FW-1:0] fcnt_q, fcnt_d;
   logic [AW:0]   eff, sum, diff;
   logic          pvalid, latch;

   always_comb begin
      nc = num_chars_i;
      if (num_chars_i == '0)        nc = NC_ONE;
      else if (num_chars_i > NC_MAX) nc = NC_MAX;
   end

   assign acc      = rx.valid & rdy_q;
   assign rx.ready = rdy_q;
   assign tick     = (cnt_q == RW'(REFRESH_DIV - 1));

   // byte parser; an ESC swallows the next byte whatever its value
   always_comb begin
      esc_d    = esc_q;
      stk_en_d = stk_en_q;
      stk_d    = stk_q;
      wp_d     = wp_q;
      we       = 1'b0;
      clr      = 1'b0;
      wcol     = stk_en_q ? stk_q : rnd_color_i;
      if (acc) begin
         unique case (1'b1)
            esc_q: begin
               esc_d = 1'b0;
               if (rx.data == ESC_NOCOLOR) stk_en_d = 1'b0;
               else begin
                  stk_en_d = 1'b1;
                  stk_d    = rx.data[3:0];
               end
            end
            (!esc_q && rx.data == CMD_ESC): esc_d = 1'b1;
            (!esc_q && is_print(rx.data)): begin
               we   = 1'b1;
               wp_d = ({1'b0, wp_q} >= nc - 1'b1) ? '0 : wp_q + 1'b1;
            end
            (!esc_q && rx.data == CMD_CLR): begin
               clr  = 1'b1;
               wp_d = '0;
            end
            (!esc_q && rx.data == CMD_HOME): wp_d = '0;
            default: ;
         endcase
      end
   end

   text_buffer #(.DEPTH(MAX_CHARS), .AW(AW)) u_buf (
      .clk     (clk),
      .rst_n   (rst_n),
      .we_i    (we),
      .waddr_i (wp_q),
      .wchar_i (rx.data),
      .wcol_i  (wcol),
      .clr_i   (clr),
      .raddr_i (slot),
      .rchar_o (rd_chr),
      .rcol_o  (rd_col)
   );

   // stale offset (nc shrank) restarts the rotation at slot 0
   always_comb begin
      eff  = ({1'b0, off_q} >= ncf_q) ? '0 : {1'b0, off_q};
      sum  = eff + {1'b0, ci_q};
      diff = sum - ncf_q;
      slot = (sum >= ncf_q) ? diff[AW-1:0] : sum[AW-1:0];
   end

   always_comb begin
      st_d   = st_q;
      ncf_d  = ncf_q;
      ci_d   = ci_q;
      bit_d  = bit_q;
      rom_d  = rom_q;
      pal_d  = pal_q;
      off_d  = off_q;
      fcnt_d = fcnt_q;
      pvalid = 1'b0;
      latch  = 1'b0;
      case (st_q)
         ST_IDLE: if (tick) begin
            ncf_d = nc;
            ci_d  = '0;
            bit_d = '0;
            st_d  = ST_LOAD;
         end
         ST_LOAD: begin
            rom_d = rd_chr;
            pal_d = rd_col;
            st_d  = ST_SEND;
         end
         ST_SEND: begin
            pvalid = 1'b1;
            if (pix.ready) begin
               if (bit_q == BW'(PIX - 1)) begin
                  bit_d = '0;
                  if ({1'b0, ci_q} == ncf_q - 1'b1) st_d = ST_LATCH;
                  else begin
                     ci_d = ci_q + 1'b1;
                     st_d = ST_LOAD;
                  end
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end
         end
         ST_LATCH: begin
            latch = 1'b1;
            st_d  = ST_IDLE;
            if (scroll_en_i) begin
               if (fcnt_q == FW'(SCROLL_DIV - 1)) begin
                  fcnt_d = '0;
                  off_d  = ({1'b0, off_q} + 1'b1 >= ncf_q) ? '0 : off_q + 1'b1;
               end else begin
                  fcnt_d = fcnt_q + 1'b1;
               end
            end
         end
         default: st_d = ST_IDLE;
      endcase
      if (clr) off_d = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdy_q    <= 1'b0;
         esc_q    <= 1'b0;
         stk_en_q <= 1'b0;
         stk_q    <= '0;
         wp_q     <= '0;
         cnt_q    <= '0;
         st_q     <= ST_IDLE;
         ncf_q    <= '0;
         ci_q     <= '0;
         bit_q    <= '0;
         rom_q    <= '0;
         pal_q    <= '0;
         off_q    <= '0;
         fcnt_q   <= '0;
      end else begin
         rdy_q    <= 1'b1;
         esc_q    <= esc_d;
         stk_en_q <= stk_en_d;
         stk_q    <= stk_d;
         wp_q     <= wp_d;
         cnt_q    <= tick ? '0 : cnt_q + 1'b1;
         st_q     <= st_d;
         ncf_q    <= ncf_d;
         ci_q     <= ci_d;
         bit_q    <= bit_d;
         rom_q    <= rom_d;
         pal_q    <= pal_d;
         off_q    <= off_d;
         fcnt_q   <= fcnt_d;
      end
   end

   assign rom_addr_o      = rom_q;
   assign pal_addr_o      = pal_q;
   assign pix.valid       = pvalid;
   assign pix.data        = (pvalid && rom_data_i[bit_q]) ? pal_data_i : '0;
   assign pix_latch_o     = latch;
   assign frame_overrun_o = tick && (st_q != ST_IDLE);
endmodule

// File: tb/tb_ledmatrix_text_engine.sv
// Bench for ledmatrix_text_engine: directed + random byte streams checked
// frame by frame against a buffer/scroll model kept in the bench.
module tb_ledmatrix_text_engine;
   localparam int MC  = 4;
   localparam int PX  = 35;
   localparam int SD  = 2;
   localparam int RD  = 1024;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [2:0]  num_chars;
   logic        scroll_en;
   logic [3:0]  rnd_color;
   logic [7:0]  rom_addr;
   logic [34:0] rom_data;
   logic [3:0]  pal_addr;
   logic [23:0] pal_data;
   logic        pix_latch, frame_overrun;

   int checks = 0;
   int failures = 0;

   ledmatrix_text_engine_if #(.W(8))  rx_if ();
   ledmatrix_text_engine_if #(.W(24)) pix_if ();

   ledmatrix_text_engine #(
      .MAX_CHARS(MC), .CHAR_W(5), .CHAR_H(7), .COLOR_W(24),
      .REFRESH_DIV(RD), .SCROLL_DIV(SD)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .num_chars_i     (num_chars),
      .scroll_en_i     (scroll_en),
      .rnd_color_i     (rnd_color),
      .rx              (rx_if),
      .rom_addr_o      (rom_addr),
      .rom_data_i      (rom_data),
      .pal_addr_o      (pal_addr),
      .pal_data_i      (pal_data),
      .pix             (pix_if),
      .pix_latch_o     (pix_latch),
      .frame_overrun_o (frame_overrun)
   );

   always #5 clk = ~clk;

   function automatic logic [34:0] glyph(input logic [7:0] a);
      logic [63:0] x;
      x = {56'h0, a} * 64'h9E3779B97F4A7C15;
      return x[34:0] ^ x[63:29];
   endfunction

   function automatic logic [23:0] pal(input logic [3:0] i);
      return {i, 4'hA, ~i, 4'h5, i, i};
   endfunction

   assign rom_data = glyph(rom_addr);
   assign pal_data = pal(pal_addr);

   // reference model state
   logic [7:0] m_text [MC];
   logic [3:0] m_col  [MC];
   int   m_wp, m_off, m_fcnt;
   bit   m_esc, m_stk_en;
   logic [3:0] m_stk;

   task automatic chk(input string tag, input logic [63:0] o,
                      input logic [63:0] e);
      checks++;
      assert (o === e) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
      end
   endtask

   function automatic int clamp_nc(input logic [2:0] n);
      if (n == 0) return 1;
      if (int'(n) > MC) return MC;
      return int'(n);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < MC; i++) begin
         m_text[i] = 8'h00;
         m_col[i]  = 4'h0;
      end
      m_wp = 0; m_off = 0; m_fcnt = 0;
      m_esc = 0; m_stk_en = 0; m_stk = 4'h0;
   endtask

   task automatic model_byte(input logic [7:0] b, input logic [3:0] rc);
      int nc;
      nc = clamp_nc(num_chars);
      if (m_esc) begin
         m_esc = 0;
         if (b == 8'hFF) m_stk_en = 0;
         else begin
            m_stk_en = 1;
            m_stk = b[3:0];
         end
      end else if (b == 8'h1B) begin
         m_esc = 1;
      end else if (b >= 8'h20 && b <= 8'h7E) begin
         m_text[m_wp] = b;
         m_col[m_wp]  = m_stk_en ? m_stk : rc;
         m_wp = (m_wp >= nc - 1) ? 0 : m_wp + 1;
      end else if (b == 8'h0C) begin
         for (int i = 0; i < MC; i++) begin
            m_text[i] = 8'h00;
            m_col[i]  = 4'h0;
         end
         m_wp = 0;
         m_off = 0;
      end else if (b == 8'h0D) begin
         m_wp = 0;
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      chk("rx_ready", rx_if.ready, 1);
      rx_if.data  = b;
      rx_if.valid = 1'b1;
      rnd_color   = 4'($urandom_range(0, 15));
      @(posedge clk);
      model_byte(b, rnd_color);
      @(negedge clk);
      rx_if.valid = 1'b0;
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send_byte(s[i]);
   endtask

   task automatic run_frame(input int pct, input int stall_at,
                            input int stall_len, output logic [7:0] fa,
                            output int nz, output bit ov);
      int ncf, eff, k, total, cyc, w, stall_left, slot;
      bit latched, stalled, pv_prev, pr_prev, acc_prev;
      logic [23:0] pd_prev;
      logic [34:0] g;
      logic [7:0]  ec [$];
      logic [3:0]  ecol [$];
      logic [23:0] ep [$];
      ncf = clamp_nc(num_chars);
      eff = (m_off >= ncf) ? 0 : m_off;
      for (int ci = 0; ci < ncf; ci++) begin
         slot = (eff + ci) % ncf;
         ec.push_back(m_text[slot]);
         ecol.push_back(m_col[slot]);
         g = glyph(m_text[slot]);
         for (int b = 0; b < PX; b++)
            ep.push_back(g[b] ? pal(m_col[slot]) : 24'h0);
      end
      total = ncf * PX;
      k = 0; nz = 0; ov = 0; cyc = 0; stall_left = 0;
      latched = 0; stalled = 0; pv_prev = 0; pr_prev = 0; acc_prev = 0;
      pd_prev = '0;
      pix_if.ready = 1'b0;
      w = 0;
      while (!pix_if.valid && w < 3 * RD) begin
         if (frame_overrun) ov = 1;
         @(negedge clk);
         w++;
      end
      chk("frame_start", pix_if.valid, 1);
      fa = rom_addr;
      while (!latched && cyc < 8000) begin
         if (frame_overrun) ov = 1;
         if (pix_latch) begin
            latched = 1;
         end else begin
            if (pv_prev && !pr_prev) begin
               chk("hold_valid", pix_if.valid, 1);
               chk("hold_data", pix_if.data, pd_prev);
            end
            if (acc_prev && k % PX == 0 && k > 0 && k < total)
               chk("load_gap", pix_if.valid, 0);
            if (!stalled && k == stall_at && stall_len > 0) begin
               stalled = 1;
               stall_left = stall_len;
            end
            if (stall_left > 0) begin
               pix_if.ready = 1'b0;
               stall_left--;
            end else begin
               pix_if.ready = ($urandom_range(0, 99) < pct);
            end
            if (pix_if.valid && k < total) begin
               chk("rom_addr", rom_addr, ec[k / PX]);
               chk("pal_addr", pal_addr, ecol[k / PX]);
            end
            acc_prev = pix_if.valid && pix_if.ready;
            if (acc_prev) begin
               if (k < total) chk("pix_data", pix_if.data, ep[k]);
               else chk("extra_pixel", k, total);
               if (pix_if.data != 0) nz++;
               k++;
            end
            pv_prev = pix_if.valid;
            pr_prev = pix_if.ready;
            pd_prev = pix_if.data;
            @(negedge clk);
            cyc++;
         end
      end
      chk("latch_seen", latched, 1);
      chk("pix_count", k, total);
      if (latched && scroll_en) begin
         if (m_fcnt == SD - 1) begin
            m_fcnt = 0;
            m_off = (m_off + 1 >= ncf) ? 0 : m_off + 1;
         end else begin
            m_fcnt++;
         end
      end
      pix_if.ready = 1'b0;
      @(negedge clk);
      chk("latch_pulse", pix_latch, 0);
   endtask

   initial begin
      logic [7:0] fa;
      int nz, w, nl, nb, r;
      bit ov;
      rst_n = 1'b0;
      num_chars = 3'd3;
      scroll_en = 1'b0;
      rnd_color = 4'h0;
      rx_if.data = 8'h00;
      rx_if.valid = 1'b0;
      pix_if.ready = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      chk("rst_rx_ready", rx_if.ready, 0);
      chk("rst_pix_valid", pix_if.valid, 0);
      chk("rst_pix_data", pix_if.data, 0);
      chk("rst_latch", pix_latch, 0);
      chk("rst_overrun", frame_overrun, 0);
      chk("rst_rom_addr", rom_addr, 0);
      chk("rst_pal_addr", pal_addr, 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rx_ready_up", rx_if.ready, 1);

      send_str("ABC");
      run_frame(100, -1, 0, fa, nz, ov);
      chk("abc_first", fa, 8'h41);

      num_chars = 3'd2;
      send_byte(8'h1B); send_byte(8'h05); send_str("XY");
      run_frame(100, -1, 0, fa, nz, ov);
      chk("xy_first", fa, 8'h58);
      chk("xy_pal", pal_addr, 5);
      send_byte(8'h1B); send_byte(8'hFF); send_str("Z");
      run_frame(100, -1, 0, fa, nz, ov);
      chk("z_first", fa, 8'h5A);

      send_str("HI");
      send_byte(8'h0C);
      run_frame(100, -1, 0, fa, nz, ov);
      chk("clr_zero_pix", nz, 0);
      chk("clr_addr", fa, 8'h00);
      send_str("Q");
      run_frame(100, -1, 0, fa, nz, ov);
      chk("clr_wp_home", fa, 8'h51);

      send_byte(8'h0C);
      num_chars = 3'd3;
      send_str("ABC");
      scroll_en = 1'b1;
      for (int f = 1; f <= 7; f++) begin
         run_frame(100, -1, 0, fa, nz, ov);
         if (f == 3) chk("scroll_f3", fa, 8'h42);
         if (f == 5) chk("scroll_f5", fa, 8'h43);
         if (f == 7) chk("scroll_f7", fa, 8'h41);
      end
      scroll_en = 1'b0;

      for (int it = 0; it < 8; it++) begin
         num_chars = 3'($urandom_range(0, 7));
         scroll_en = 1'($urandom_range(0, 1));
         nb = $urandom_range(1, 6);
         for (int j = 0; j < nb; j++) begin
            r = $urandom_range(0, 9);
            if (r <= 5) send_byte(8'($urandom_range(32, 126)));
            else if (r == 6) begin
               send_byte(8'h1B);
               send_byte(($urandom_range(0, 3) == 0) ? 8'hFF
                                                       : 8'($urandom_range(0, 254)));
            end else if (r == 7) send_byte(8'h0D);
            else if (r == 8) send_byte(8'h0C);
            else send_byte(8'($urandom_range(128, 255)));
         end
         run_frame($urandom_range(50, 100), -1, 0, fa, nz, ov);
      end
      scroll_en = 1'b0;

      num_chars = 3'd4;
      run_frame(100, 40, RD + 80, fa, nz, ov);
      chk("overrun_seen", ov, 1);
      run_frame(70, -1, 0, fa, nz, ov);

      w = 0;
      while (!pix_if.valid && w < 3 * RD) begin
         @(negedge clk);
         w++;
      end
      chk("mid_send", pix_if.valid, 1);
      pix_if.ready = 1'b1;
      repeat (10) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("abort_valid", pix_if.valid, 0);
      chk("abort_latch", pix_latch, 0);
      chk("abort_rx_ready", rx_if.ready, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      nl = 0;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         if (pix_latch || pix_if.valid) nl++;
      end
      chk("no_abort_latch", nl, 0);
      run_frame(100, -1, 0, fa, nz, ov);
      chk("post_rst_zero", nz, 0);
      chk("post_rst_addr", fa, 8'h00);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
